// File: rtl/ec_point_octet_encoder.sv
// Streams an EC point or scalar as a big-endian SEC1 octet string, one byte per beat.
// A request is latched, validated for one cycle, and then sent as prefix, X bytes and Y bytes.
module ec_point_octet_encoder #(
   parameter int MAX_BYTES = 66,
   parameter int LEN_W     = 7
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [1:0]               req_mode,
   input  logic [LEN_W-1:0]         req_len,
   input  logic [8*MAX_BYTES-1:0]   req_x,
   input  logic [8*MAX_BYTES-1:0]   req_y,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [7:0]               out_data,
   output logic                     out_last,
   output logic [LEN_W+1:0]         enc_len,
   output logic                     err,
   output logic                     busy
);

   localparam int CW = LEN_W + 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_PREFIX,
      S_XOUT,
      S_YOUT
   } state_t;

   state_t                       state_reg, state_next;
   logic [1:0]                   mode_reg;
   logic [LEN_W-1:0]             len_reg;
   logic [MAX_BYTES-1:0][7:0]    x_reg, y_reg;
   logic [LEN_W-1:0]             byte_idx_reg, byte_idx_next;
   logic [CW-1:0]                cnt_reg, cnt_next;
   logic [CW-1:0]                enc_len_reg, enc_len_next;
   logic                         err_reg, err_next;
   logic [MAX_BYTES-1:0]         x_hi, y_hi;
   logic                         req_bad;
   logic                         accept;
   logic                         fire;

   // Flag every coordinate byte that lies beyond the requested field size yet is nonzero.
   generate
      for (genvar gi = 0; gi < MAX_BYTES; gi++) begin : g_range
         assign x_hi[gi] = (len_reg <= LEN_W'(gi)) && (x_reg[gi] != 8'd0);
         assign y_hi[gi] = (len_reg <= LEN_W'(gi)) && (y_reg[gi] != 8'd0);
      end
   endgenerate

   assign req_bad = (len_reg == '0) || (len_reg > LEN_W'(MAX_BYTES)) || (|x_hi)
                    || ((mode_reg != 2'b00) && (|y_hi));

   assign req_ready = rst_n && (state_reg == S_IDLE);
   assign busy      = (state_reg != S_IDLE);
   assign out_valid = (state_reg == S_PREFIX) || (state_reg == S_XOUT) || (state_reg == S_YOUT);
   assign out_last  = out_valid && (cnt_reg == enc_len_reg);
   assign enc_len   = enc_len_reg;
   assign err       = err_reg;
   assign accept    = req_valid && req_ready;
   assign fire      = out_valid && out_ready;

   always_comb begin
      out_data = 8'd0;
      case (state_reg)
         S_PREFIX: begin
            case (mode_reg)
               2'b01:   out_data = 8'h02 | {7'd0, y_reg[0][0]};
               2'b10:   out_data = 8'h04;
               default: out_data = 8'h06 | {7'd0, y_reg[0][0]};
            endcase
         end
         S_XOUT:  out_data = x_reg[byte_idx_reg];
         S_YOUT:  out_data = y_reg[byte_idx_reg];
         default: out_data = 8'd0;
      endcase
   end

   always_comb begin
      state_next    = state_reg;
      byte_idx_next = byte_idx_reg;
      cnt_next      = cnt_reg;
      enc_len_next  = enc_len_reg;
      err_next      = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (accept) state_next = S_CHECK;
         end
         S_CHECK: begin
            if (req_bad) begin
               state_next = S_IDLE;
               err_next   = 1'b1;
            end else begin
               state_next    = (mode_reg == 2'b00) ? S_XOUT : S_PREFIX;
               byte_idx_next = len_reg - LEN_W'(1);
               cnt_next      = CW'(1);
               case (mode_reg)
                  2'b00:   enc_len_next = CW'(len_reg);
                  2'b01:   enc_len_next = CW'(len_reg) + CW'(1);
                  default: enc_len_next = (CW'(len_reg) << 1) + CW'(1);
               endcase
            end
         end
         S_PREFIX: begin
            if (fire) begin
               state_next = S_XOUT;
               cnt_next   = cnt_reg + CW'(1);
            end
         end
         S_XOUT: begin
            if (fire) begin
               cnt_next = cnt_reg + CW'(1);
               if (byte_idx_reg == '0) begin
                  if (mode_reg[1]) begin
                     state_next    = S_YOUT;
                     byte_idx_next = len_reg - LEN_W'(1);
                  end else begin
                     state_next = S_IDLE;
                  end
               end else begin
                  byte_idx_next = byte_idx_reg - LEN_W'(1);
               end
            end
         end
         S_YOUT: begin
            if (fire) begin
               cnt_next = cnt_reg + CW'(1);
               if (byte_idx_reg == '0) state_next = S_IDLE;
               else                    byte_idx_next = byte_idx_reg - LEN_W'(1);
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= S_IDLE;
         mode_reg     <= 2'b00;
         len_reg      <= '0;
         x_reg        <= '0;
         y_reg        <= '0;
         byte_idx_reg <= '0;
         cnt_reg      <= '0;
         enc_len_reg  <= '0;
         err_reg      <= 1'b0;
      end else begin
         state_reg    <= state_next;
         byte_idx_reg <= byte_idx_next;
         cnt_reg      <= cnt_next;
         enc_len_reg  <= enc_len_next;
         err_reg      <= err_next;
         if (accept) begin
            mode_reg <= req_mode;
            len_reg  <= req_len;
            x_reg    <= req_x;
            y_reg    <= req_y;
         end
      end
   end

endmodule

// File: tb/tb_ec_point_octet_encoder.sv
// Bench for ec_point_octet_encoder: directed cases plus random requests, checked against
// a byte-queue model of the SEC1 encoding.
module tb_ec_point_octet_encoder;

   localparam int MB = 66;
   localparam int LW = 7;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              req_valid;
   logic              req_ready;
   logic [1:0]        req_mode;
   logic [LW-1:0]     req_len;
   logic [8*MB-1:0]   req_x;
   logic [8*MB-1:0]   req_y;
   logic              out_valid;
   logic              out_ready;
   logic [7:0]        out_data;
   logic              out_last;
   logic [LW+1:0]     enc_len;
   logic              err;
   logic              busy;

   int          total = 0;
   int          bad = 0;
   logic [7:0]  exp_q[$];
   int          exp_len_g = 0;
   int          rdy_pct = 100;
   bit          mon_en = 1'b0;
   int          hs_count = 0;
   bit          prev_valid = 1'b0;
   bit          prev_hs = 1'b0;
   logic [7:0]  prev_data = 8'd0;
   logic        prev_last = 1'b0;

   ec_point_octet_encoder #(.MAX_BYTES(MB), .LEN_W(LW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_mode  (req_mode),
      .req_len   (req_len),
      .req_x     (req_x),
      .req_y     (req_y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .enc_len   (enc_len),
      .err       (err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #800000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference encoding: validity from value ranges, bytes from plain big-endian slicing.
   task automatic build_exp(input logic [1:0] m, input int len, input logic [8*MB-1:0] xv,
                            input logic [8*MB-1:0] yv, output bit ok);
      exp_q.delete();
      ok = (len >= 1) && (len <= MB);
      if (ok && ((xv >> (8*len)) != '0)) ok = 1'b0;
      if (ok && (m != 2'b00) && ((yv >> (8*len)) != '0)) ok = 1'b0;
      if (ok) begin
         if (m == 2'b01) exp_q.push_back(8'h02 + {7'd0, yv[0]});
         if (m == 2'b10) exp_q.push_back(8'h04);
         if (m == 2'b11) exp_q.push_back(8'h06 + {7'd0, yv[0]});
         for (int i = len - 1; i >= 0; i--) exp_q.push_back(xv[8*i +: 8]);
         if (m[1]) for (int i = len - 1; i >= 0; i--) exp_q.push_back(yv[8*i +: 8]);
         exp_len_g = exp_q.size();
      end
   endtask

   function automatic logic [8*MB-1:0] rnd_val(input int len);
      logic [8*MB-1:0] v;
      logic [8*MB-1:0] mask;
      for (int w = 0; w < 16; w++) v[32*w +: 32] = $urandom();
      v[8*MB-1:512] = 16'($urandom());
      if (len >= MB) mask = '1;
      else           mask = ((8*MB)'(1) << (8*len)) - (8*MB)'(1);
      return v & mask;
   endfunction

   // Single compare process: checks every beat, holds across stalls, drives out_ready.
   always @(negedge clk) begin
      bit new_rdy;
      if (mon_en) begin
         if (prev_valid && !prev_hs) begin
            chk("stall_valid_hold", 64'(out_valid), 64'(1));
            chk("stall_data_hold", 64'(out_data), 64'(prev_data));
            chk("stall_last_hold", 64'(out_last), 64'(prev_last));
         end
         if (out_valid) begin
            chk("err_with_valid", 64'(err), 64'(0));
            chk("beat_expected", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
               chk("beat_data", 64'(out_data), 64'(exp_q[0]));
               chk("beat_last", 64'(out_last), 64'(exp_q.size() == 1));
               chk("beat_enc_len", 64'(enc_len), 64'(exp_len_g));
            end
         end
         new_rdy    = ($urandom_range(99) < rdy_pct);
         out_ready  = new_rdy;
         prev_valid = out_valid;
         prev_hs    = out_valid && new_rdy;
         prev_data  = out_data;
         prev_last  = out_last;
         if (prev_hs && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            hs_count++;
         end
      end else begin
         out_ready  = 1'b0;
         prev_valid = 1'b0;
         prev_hs    = 1'b0;
      end
   end

   task automatic start_req(input logic [1:0] m, input int len, input logic [8*MB-1:0] xv,
                            input logic [8*MB-1:0] yv, input int pct, input int first_byte,
                            input int exp_enc, output bit ok);
      int budget;
      build_exp(m, len, xv, yv, ok);
      rdy_pct  = pct;
      hs_count = 0;
      budget   = 0;
      while (!req_ready && budget < 300) begin
         @(negedge clk);
         budget++;
      end
      chk("ready_before_req", 64'(req_ready), 64'(1));
      req_valid = 1'b1;
      req_mode  = m;
      req_len   = LW'(len);
      req_x     = xv;
      req_y     = yv;
      @(negedge clk);
      // Held valid with garbage while busy: must be ignored.
      req_mode = 2'($urandom());
      req_len  = LW'($urandom());
      req_x    = rnd_val(MB);
      req_y    = rnd_val(MB);
      chk("check_cycle_valid", 64'(out_valid), 64'(0));
      chk("check_cycle_err", 64'(err), 64'(0));
      chk("check_cycle_busy", 64'(busy), 64'(1));
      @(negedge clk);
      req_valid = 1'b0;
      if (!ok) begin
         chk("reject_err", 64'(err), 64'(1));
         chk("reject_valid", 64'(out_valid), 64'(0));
         chk("reject_ready", 64'(req_ready), 64'(1));
         @(negedge clk);
         chk("reject_err_pulse", 64'(err), 64'(0));
         chk("reject_valid_after", 64'(out_valid), 64'(0));
      end else begin
         chk("first_valid_latency", 64'(out_valid), 64'(1));
         if (first_byte >= 0) chk("first_byte_literal", 64'(out_data), 64'(first_byte));
         if (exp_enc >= 0) chk("enc_len_literal", 64'(enc_len), 64'(exp_enc));
      end
   endtask

   task automatic finish_req();
      int budget = 0;
      while ((exp_q.size() != 0 || busy) && budget < 3000) begin
         @(negedge clk);
         budget++;
      end
      chk("stream_complete", 64'(exp_q.size()), 64'(0));
      chk("idle_after_stream", 64'(req_ready), 64'(1));
   endtask

   task automatic run_req(input logic [1:0] m, input int len, input logic [8*MB-1:0] xv,
                          input logic [8*MB-1:0] yv, input int pct, input int first_byte,
                          input int exp_enc);
      bit ok;
      start_req(m, len, xv, yv, pct, first_byte, exp_enc, ok);
      if (ok) finish_req();
   endtask

   initial begin
      logic [8*MB-1:0] x1, y1, xv, yv;
      bit              ok;
      int              len;
      int              r;
      logic [1:0]      m;

      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_mode  = 2'b00;
      req_len   = '0;
      req_x     = '0;
      req_y     = '0;
      repeat (3) @(negedge clk);
      chk("reset_req_ready", 64'(req_ready), 64'(0));
      chk("reset_out_valid", 64'(out_valid), 64'(0));
      chk("reset_err", 64'(err), 64'(0));
      chk("reset_busy", 64'(busy), 64'(0));
      chk("reset_enc_len", 64'(enc_len), 64'(0));
      chk("reset_out_last", 64'(out_last), 64'(0));
      chk("reset_out_data", 64'(out_data), 64'(0));
      rst_n  = 1'b1;
      mon_en = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", 64'(req_ready), 64'(1));

      // Test 1: x = 0x0102..20, y = 0x2122..40
      x1 = '0;
      y1 = '0;
      for (int i = 0; i < 32; i++) begin
         x1[8*i +: 8] = 8'(32 - i);
         y1[8*i +: 8] = 8'(64 - i);
      end
      build_exp(2'b10, 32, x1, y1, ok);
      chk("model_t1_size", 64'(exp_q.size()), 64'(65));
      chk("model_t1_b1", 64'(exp_q[0]), 64'(8'h04));
      chk("model_t1_b2", 64'(exp_q[1]), 64'(8'h01));
      chk("model_t1_b65", 64'(exp_q[64]), 64'(8'h40));
      run_req(2'b10, 32, x1, y1, 100, 8'h04, 65);

      // Test 2: compressed and hybrid prefixes follow y parity
      xv = rnd_val(48);
      yv = rnd_val(48);
      yv[0] = 1'b1;
      run_req(2'b01, 48, xv, yv, 100, 8'h03, 49);
      yv[0] = 1'b0;
      run_req(2'b01, 48, xv, yv, 100, 8'h02, 49);
      yv[0] = 1'b1;
      run_req(2'b11, 48, xv, yv, 100, 8'h07, 97);
      yv[0] = 1'b0;
      run_req(2'b11, 48, xv, yv, 100, 8'h06, 97);

      // Test 3: scalar padding to full P-521 size
      xv = (8*MB)'(1);
      run_req(2'b00, 66, xv, rnd_val(MB), 100, 8'h00, 66);

      // Test 4: rejects
      run_req(2'b10, 0, '0, '0, 100, -1, -1);
      run_req(2'b10, 67, '0, '0, 100, -1, -1);
      xv = rnd_val(32);
      xv[256] = 1'b1;
      run_req(2'b00, 32, xv, '0, 100, -1, -1);
      yv = rnd_val(32);
      yv[300] = 1'b1;
      run_req(2'b10, 32, rnd_val(32), yv, 100, -1, -1);

      // Test 5: backpressure on the test 1 vector
      run_req(2'b10, 32, x1, y1, 50, 8'h04, 65);

      // Test 6: reset in the middle of XOUT
      start_req(2'b10, 32, x1, y1, 100, 8'h04, 65, ok);
      begin
         int budget = 0;
         while (hs_count < 10 && budget < 200) begin
            @(negedge clk);
            budget++;
         end
      end
      chk("reset_test_progress", 64'(hs_count >= 10), 64'(1));
      mon_en = 1'b0;
      rst_n  = 1'b0;
      @(negedge clk);
      chk("midreset_valid", 64'(out_valid), 64'(0));
      chk("midreset_last", 64'(out_last), 64'(0));
      chk("midreset_data", 64'(out_data), 64'(0));
      chk("midreset_busy", 64'(busy), 64'(0));
      chk("midreset_enc_len", 64'(enc_len), 64'(0));
      chk("midreset_ready", 64'(req_ready), 64'(0));
      chk("midreset_err", 64'(err), 64'(0));
      exp_q.delete();
      rst_n  = 1'b1;
      mon_en = 1'b1;
      @(negedge clk);
      chk("ready_after_midreset", 64'(req_ready), 64'(1));
      xv = rnd_val(32);
      yv = rnd_val(32);
      yv[0] = 1'b1;
      run_req(2'b01, 32, xv, yv, 100, 8'h03, 33);

      // Random requests with random backpressure
      for (int n = 0; n < 40; n++) begin
         r = $urandom_range(9);
         m = 2'($urandom());
         if (r <= 5)      len = (r % 3 == 0) ? 32 : ((r % 3 == 1) ? 48 : 66);
         else if (r <= 7) len = $urandom_range(1, 66);
         else if (r == 8) len = ($urandom_range(1) == 0) ? 0 : $urandom_range(67, 127);
         else             len = $urandom_range(1, 65);
         xv = rnd_val(len > MB ? MB : len);
         yv = rnd_val(len > MB ? MB : len);
         if (r == 9) begin
            if ($urandom_range(1) == 0) xv[$urandom_range(8*len, 8*MB-1)] = 1'b1;
            else                        yv[$urandom_range(8*len, 8*MB-1)] = 1'b1;
         end
         run_req(m, len, xv, yv, $urandom_range(30, 100), -1, -1);
      end

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
